// File: rtl/conv_layer_sched_pkg.sv
// Shared types, geometry and tap-offset helper for the two-layer CNN sequencer.
package conv_layer_sched_pkg;

  localparam int unsigned IMG_W  = 64;
  localparam int unsigned POOL_W = IMG_W / 2;
  localparam int unsigned AW     = $clog2(IMG_W * IMG_W);
  localparam int unsigned RW     = $clog2(IMG_W);
  localparam int unsigned PW     = $clog2(POOL_W);

  localparam logic [2:0] CSEL_IDLE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StCwr,
    StPool,
    StPwr,
    StDone
  } state_e;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } tap_off_t;

  // Row/column offset of 3x3 tap k, two's complement {dr, dc}: -1 = 2'b11.
  function automatic tap_off_t tap_offset(input logic [3:0] k);
    tap_off_t o;
    case (k)
      4'd0:    o = 4'b1111;
      4'd1:    o = 4'b1100;
      4'd2:    o = 4'b1101;
      4'd3:    o = 4'b0011;
      4'd4:    o = 4'b0000;
      4'd5:    o = 4'b0001;
      4'd6:    o = 4'b0111;
      4'd7:    o = 4'b0100;
      4'd8:    o = 4'b0101;
      default: o = 4'b0000;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/conv_layer_sched_if.sv
// Host/datapath handshake, image address and layer-memory strobes of the sequencer.
interface conv_layer_sched_if;
  import conv_layer_sched_pkg::*;

  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic          pad;
  logic [3:0]    kidx;
  logic          mac_first;
  logic          mac_en;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [2:0]    csel;
  logic          pool_first;
  logic          pool_en;

  modport master (
    input  ready,
    output busy, iaddr, pad, kidx, mac_first, mac_en, crd, caddr_rd, cwr, caddr_wr, csel,
           pool_first, pool_en
  );

  modport slave (
    output ready,
    input  busy, iaddr, pad, kidx, mac_first, mac_en, crd, caddr_rd, cwr, caddr_wr, csel,
           pool_first, pool_en
  );

endinterface

// File: rtl/conv_layer_sched_tap_addr.sv
// Combinational neighbour address for pixel (r,c) and 3x3 tap k, with zero-pad flag.
module conv_layer_sched_tap_addr
  import conv_layer_sched_pkg::*;
(
  input  logic [RW-1:0] r,
  input  logic [RW-1:0] c,
  input  logic [3:0]    k,
  output logic          pad,
  output logic [AW-1:0] iaddr
);

  tap_off_t      off;
  logic [RW+1:0] rr;
  logic [RW+1:0] cc;

  // Two guard bits: -1 sets the top bit, IMG_W sets the next one.
  always_comb begin
    off   = tap_offset(k);
    rr    = {2'b00, r} + {{RW{off.dr[1]}}, off.dr};
    cc    = {2'b00, c} + {{RW{off.dc[1]}}, off.dc};
    pad   = (|rr[RW+1:RW]) | (|cc[RW+1:RW]);
    iaddr = pad ? '0 : {rr[RW-1:0], cc[RW-1:0]};
  end

endmodule

// File: rtl/conv_layer_sched.sv
// Sequencer: 3x3 padded convolution into layer 0, then 2x2 max-pool into layer 1.
module conv_layer_sched
  import conv_layer_sched_pkg::*;
(
  input logic                clk,
  input logic                reset,
  conv_layer_sched_if.master bus
);

  localparam logic [AW-1:0]   LastPixel = AW'(IMG_W * IMG_W - 1);
  localparam logic [2*PW-1:0] LastPool  = (2 * PW)'(POOL_W * POOL_W - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   pixel_q, pixel_d;
  logic [3:0]      k_q, k_d;
  logic [2*PW-1:0] p_q, p_d;
  logic [1:0]      j_q, j_d;

  logic          busy_q, pad_q, mac_en_q, mac_first_q, crd_q, cwr_q, pool_en_q, pool_first_q;
  logic          busy_d, pad_d, mac_en_d, mac_first_d, crd_d, cwr_d, pool_en_d, pool_first_d;
  logic [AW-1:0] iaddr_q, caddr_rd_q, caddr_wr_q;
  logic [AW-1:0] iaddr_d, caddr_rd_d, caddr_wr_d;
  logic [3:0]    kidx_q, kidx_d;
  logic [2:0]    csel_q, csel_d;

  logic          tap_pad;
  logic [AW-1:0] tap_iaddr;
  logic [AW-1:0] pool_addr;

  always_comb begin
    state_d = state_q;
    pixel_d = pixel_q;
    k_d     = k_q;
    p_d     = p_q;
    j_d     = j_q;
    unique case (state_q)
      StIdle: if (bus.ready) begin
        state_d = StConv;
        pixel_d = '0;
        k_d     = '0;
      end
      StConv: if (k_q == 4'd8) state_d = StCwr;
              else k_d = k_q + 4'd1;
      StCwr: if (pixel_q == LastPixel) begin
        state_d = StPool;
        p_d     = '0;
        j_d     = '0;
      end else begin
        state_d = StConv;
        pixel_d = pixel_q + 1'b1;
        k_d     = '0;
      end
      StPool: if (j_q == 2'd3) state_d = StPwr;
              else j_d = j_q + 2'd1;
      StPwr: if (p_q == LastPool) state_d = StDone;
      else begin
        state_d = StPool;
        p_d     = p_q + 1'b1;
        j_d     = '0;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the state being entered so they register alongside it.
  conv_layer_sched_tap_addr u_tap_addr (
    .r     (pixel_d[AW-1:RW]),
    .c     (pixel_d[RW-1:0]),
    .k     (k_d),
    .pad   (tap_pad),
    .iaddr (tap_iaddr)
  );

  // j[1] steps down a row, j[0] steps right a column within the 2x2 window.
  assign pool_addr = {p_d[2*PW-1:PW], j_d[1], p_d[PW-1:0], j_d[0]};

  always_comb begin
    busy_d       = (state_d != StIdle) && (state_d != StDone);
    mac_en_d     = (state_d == StConv);
    mac_first_d  = (state_d == StConv) && (k_d == 4'd0);
    kidx_d       = (state_d == StConv) ? k_d : 4'd0;
    pad_d        = (state_d == StConv) && tap_pad;
    iaddr_d      = (state_d == StConv) ? tap_iaddr : '0;
    crd_d        = (state_d == StPool);
    pool_en_d    = (state_d == StPool);
    pool_first_d = (state_d == StPool) && (j_d == 2'd0);
    caddr_rd_d   = (state_d == StPool) ? pool_addr : '0;
    cwr_d        = (state_d == StCwr) || (state_d == StPwr);
    caddr_wr_d   = '0;
    csel_d       = CSEL_IDLE;
    if (state_d == StCwr) begin
      caddr_wr_d = pixel_d;
      csel_d     = CSEL_L0;
    end else if (state_d == StPool) begin
      csel_d     = CSEL_L0;
    end else if (state_d == StPwr) begin
      caddr_wr_d = AW'(p_d);
      csel_d     = CSEL_L1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pixel_q      <= '0;
      k_q          <= '0;
      p_q          <= '0;
      j_q          <= '0;
      busy_q       <= 1'b0;
      pad_q        <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_first_q  <= 1'b0;
      crd_q        <= 1'b0;
      cwr_q        <= 1'b0;
      pool_en_q    <= 1'b0;
      pool_first_q <= 1'b0;
      iaddr_q      <= '0;
      caddr_rd_q   <= '0;
      caddr_wr_q   <= '0;
      kidx_q       <= '0;
      csel_q       <= CSEL_IDLE;
    end else begin
      state_q      <= state_d;
      pixel_q      <= pixel_d;
      k_q          <= k_d;
      p_q          <= p_d;
      j_q          <= j_d;
      busy_q       <= busy_d;
      pad_q        <= pad_d;
      mac_en_q     <= mac_en_d;
      mac_first_q  <= mac_first_d;
      crd_q        <= crd_d;
      cwr_q        <= cwr_d;
      pool_en_q    <= pool_en_d;
      pool_first_q <= pool_first_d;
      iaddr_q      <= iaddr_d;
      caddr_rd_q   <= caddr_rd_d;
      caddr_wr_q   <= caddr_wr_d;
      kidx_q       <= kidx_d;
      csel_q       <= csel_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.pad        = pad_q;
  assign bus.mac_en     = mac_en_q;
  assign bus.mac_first  = mac_first_q;
  assign bus.crd        = crd_q;
  assign bus.cwr        = cwr_q;
  assign bus.pool_en    = pool_en_q;
  assign bus.pool_first = pool_first_q;
  assign bus.iaddr      = iaddr_q;
  assign bus.caddr_rd   = caddr_rd_q;
  assign bus.caddr_wr   = caddr_wr_q;
  assign bus.kidx       = kidx_q;
  assign bus.csel       = csel_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Self-checking bench: cycle-indexed reference of a whole run compared on every negedge.
module tb_conv_layer_sched;

  localparam int NPIX     = 64 * 64;
  localparam int NPOOL    = 32 * 32;
  localparam int CONV_LEN = NPIX * 10;
  localparam int RUN_LEN  = CONV_LEN + NPOOL * 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  conv_layer_sched_if bus ();

  conv_layer_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference: phase 0 idle, 1 running at cycle index t, 2 the single done cycle.
  int ph = 0;
  int t = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph <= 0;
      t  <= 0;
    end else begin
      case (ph)
        0: if (bus.ready) begin ph <= 1; t <= 0; end
        1: if (t == RUN_LEN - 1) ph <= 2; else t <= t + 1;
        default: ph <= 0;
      endcase
    end
  end

  logic count_en = 1'b0;
  logic lit_go = 1'b0;
  logic lit_done = 1'b0;
  int busy_cnt = 0, wr0_cnt = 0, wr1_cnt = 0, dup_cnt = 0;
  bit wr0_seen[NPIX];
  bit wr1_seen[NPOOL];
  int wstart[4] = '{0, 650, 40950, 41125};
  int cap_pad[4][10], cap_ia[4][10], cap_cwr[4][10], cap_cwa[4][10], cap_csel[4][10];
  int cap_crd[4][10], cap_cra[4][10], cap_pf[4][10];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " crd"}, int'(bus.crd), 0);
    chk({tag, " cwr"}, int'(bus.cwr), 0);
    chk({tag, " csel"}, int'(bus.csel), 0);
    chk({tag, " iaddr"}, int'(bus.iaddr), 0);
    chk({tag, " caddr_rd"}, int'(bus.caddr_rd), 0);
    chk({tag, " caddr_wr"}, int'(bus.caddr_wr), 0);
    chk({tag, " kidx"}, int'(bus.kidx), 0);
    chk({tag, " pad"}, int'(bus.pad), 0);
    chk({tag, " mac_en"}, int'(bus.mac_en), 0);
    chk({tag, " mac_first"}, int'(bus.mac_first), 0);
    chk({tag, " pool_en"}, int'(bus.pool_en), 0);
    chk({tag, " pool_first"}, int'(bus.pool_first), 0);
  endtask

  task automatic check_cycle();
    int e_busy = 0, e_mac = 0, e_mf = 0, e_k = 0, e_pad = 0, e_ia = 0;
    int e_cwr = 0, e_cwa = 0, e_csel = 0, e_crd = 0, e_cra = 0, e_pe = 0, e_pf = 0;
    if (ph == 1) begin
      e_busy = 1;
      if (t < CONV_LEN) begin
        int pix = t / 10, k = t % 10;
        if (k < 9) begin
          int rr = pix / 64 + k / 3 - 1, cc = pix % 64 + k % 3 - 1;
          e_mac = 1; e_mf = (k == 0); e_k = k;
          if (rr < 0 || rr > 63 || cc < 0 || cc > 63) e_pad = 1;
          else e_ia = rr * 64 + cc;
        end else begin
          e_cwr = 1; e_cwa = pix; e_csel = 1;
        end
      end else begin
        int p = (t - CONV_LEN) / 5, j = (t - CONV_LEN) % 5;
        if (j < 4) begin
          e_crd = 1; e_pe = 1; e_pf = (j == 0); e_csel = 1;
          e_cra = (2 * (p / 32) + j / 2) * 64 + 2 * (p % 32) + j % 2;
        end else begin
          e_cwr = 1; e_cwa = p; e_csel = 3;
        end
      end
    end
    chk("busy", int'(bus.busy), e_busy);
    chk("mac_en", int'(bus.mac_en), e_mac);
    chk("mac_first", int'(bus.mac_first), e_mf);
    chk("cwr", int'(bus.cwr), e_cwr);
    chk("csel", int'(bus.csel), e_csel);
    chk("crd", int'(bus.crd), e_crd);
    chk("pool_en", int'(bus.pool_en), e_pe);
    chk("pool_first", int'(bus.pool_first), e_pf);
    if (e_mac == 1) begin
      chk("kidx", int'(bus.kidx), e_k);
      chk("pad", int'(bus.pad), e_pad);
      chk("iaddr", int'(bus.iaddr), e_ia);
    end
    if (e_cwr == 1) chk("caddr_wr", int'(bus.caddr_wr), e_cwa);
    if (e_crd == 1) chk("caddr_rd", int'(bus.caddr_rd), e_cra);

    if (count_en) begin
      if (bus.busy) busy_cnt++;
      if (bus.cwr && bus.csel == 3'b001) begin
        wr0_cnt++;
        if (wr0_seen[int'(bus.caddr_wr)]) dup_cnt++;
        wr0_seen[int'(bus.caddr_wr)] = 1'b1;
      end
      if (bus.cwr && bus.csel == 3'b011) begin
        wr1_cnt++;
        if (int'(bus.caddr_wr) >= NPOOL) dup_cnt++;
        else begin
          if (wr1_seen[int'(bus.caddr_wr)]) dup_cnt++;
          wr1_seen[int'(bus.caddr_wr)] = 1'b1;
        end
      end
      if (ph == 1) begin
        for (int w = 0; w < 4; w++) begin
          if (t >= wstart[w] && t < wstart[w] + 10) begin
            int i = t - wstart[w];
            cap_pad[w][i] = int'(bus.pad);   cap_ia[w][i] = int'(bus.iaddr);
            cap_cwr[w][i] = int'(bus.cwr);   cap_cwa[w][i] = int'(bus.caddr_wr);
            cap_csel[w][i] = int'(bus.csel); cap_crd[w][i] = int'(bus.crd);
            cap_cra[w][i] = int'(bus.caddr_rd); cap_pf[w][i] = int'(bus.pool_first);
          end
        end
      end
    end
  endtask

  // Hand-computed expectations for the corner pixels and one pool window.
  task automatic check_literals();
    int pad0[9], ia0[9], ia65[9], pad_last[9], ia_last[9], cra33[4], pf33[4];
    pad0 = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
    ia0 = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
    ia65 = '{0, 1, 2, 64, 65, 66, 128, 129, 130};
    pad_last = '{0, 0, 1, 0, 0, 1, 1, 1, 1};
    ia_last = '{4030, 4031, 0, 4094, 4095, 0, 0, 0, 0};
    cra33 = '{130, 131, 194, 195};
    pf33 = '{1, 0, 0, 0};
    for (int k = 0; k < 9; k++) begin
      chk("px0 pad", cap_pad[0][k], pad0[k]);
      chk("px0 iaddr", cap_ia[0][k], ia0[k]);
      chk("px65 pad", cap_pad[1][k], 0);
      chk("px65 iaddr", cap_ia[1][k], ia65[k]);
      chk("px4095 pad", cap_pad[2][k], pad_last[k]);
      chk("px4095 iaddr", cap_ia[2][k], ia_last[k]);
    end
    chk("px0 cwr", cap_cwr[0][9], 1);
    chk("px0 caddr_wr", cap_cwa[0][9], 0);
    chk("px0 csel", cap_csel[0][9], 1);
    chk("px4095 caddr_wr", cap_cwa[2][9], 4095);
    for (int j = 0; j < 4; j++) begin
      chk("pool33 crd", cap_crd[3][j], 1);
      chk("pool33 caddr_rd", cap_cra[3][j], cra33[j]);
      chk("pool33 pool_first", cap_pf[3][j], pf33[j]);
    end
    chk("pool33 cwr", cap_cwr[3][4], 1);
    chk("pool33 caddr_wr", cap_cwa[3][4], 33);
    chk("pool33 csel", cap_csel[3][4], 3);
    chk("busy cycles", busy_cnt, 46080);
    chk("layer0 writes", wr0_cnt, 4096);
    chk("layer1 writes", wr1_cnt, 1024);
    chk("duplicate writes", dup_cnt, 0);
  endtask

  // Single compare process; a falling reset is checked 1 time unit later.
  initial begin
    logic r0;
    forever begin
      r0 = reset;
      @(negedge clk or negedge reset);
      if (r0 && !reset) begin
        #1;
        check_reset_vals("async reset");
      end else if (!clk) begin
        if (!reset) check_reset_vals("reset");
        else check_cycle();
        if (lit_go && !lit_done) begin
          check_literals();
          lit_done = 1'b1;
        end
      end
    end
  end

  initial begin
    int n;
    bus.ready = 1'b1;
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;

    // First run, aborted by reset at run cycle 20000.
    n = 0;
    while (!(ph == 1 && t == 19999)) begin
      @(negedge clk);
      bus.ready = 1'($urandom_range(0, 1));
      if (++n > 25000) begin
        $display("FAIL timeout waiting for run cycle 20000");
        $fatal(1, "timeout");
      end
    end
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus.ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.ready = 1'b0;
    reset = 1'b1;
    repeat ($urandom_range(1, 20)) @(negedge clk);

    // Full run from a fresh start, with ready noise that must be ignored.
    count_en = 1'b1;
    bus.ready = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ph == 2) break;
      bus.ready = 1'($urandom_range(0, 1));
      if (++n > RUN_LEN + 100) begin
        $display("FAIL timeout waiting for run completion");
        $fatal(1, "timeout");
      end
    end
    bus.ready = 1'b0;
    repeat (4) @(negedge clk);
    count_en = 1'b0;
    lit_go = 1'b1;
    n = 0;
    while (!lit_done) begin
      @(negedge clk);
      if (++n > 5) begin
        $display("FAIL timeout waiting for literal checks");
        $fatal(1, "timeout");
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_layer_sched.md
# conv_layer_sched

Sequencing controller for the two-layer CNN engine: 3×3 zero-padded convolution over the 64×64 input image into layer-0 memory, then 2×2 stride-2 max-pooling into layer-1 memory. Owns the `ready`/`busy` handshake, image and layer-memory address generation, `csel`/`crd`/`cwr` strobes, and per-cycle control of the MAC/ReLU and pooling-compare datapath. Arithmetic stays in the datapath; this block issues only addresses and enables.

## Interface
- IMG_W, 64: image width and height in pixels (power of two).
- POOL_W, 32: pooled width, IMG_W/2.
- AW, 12: address width, log2(IMG_W*IMG_W).

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ready  in  1  host has image loaded; start request
- busy  out  1  high from accepted start to end of final layer-1 write
- iaddr  out  AW  image read address; `idata` sampled by datapath in the same cycle
- pad  out  1  current tap is outside the image; datapath forces operand to 0
- kidx  out  4  kernel tap index 0..8
- mac_first  out  1  tap 0: datapath loads the product instead of accumulating
- mac_en  out  1  tap cycle active
- crd  out  1  layer-memory read strobe
- caddr_rd  out  AW  layer-memory read address
- cwr  out  1  layer-memory write strobe
- caddr_wr  out  AW  layer-memory write address
- csel  out  3  000 idle, 001 layer 0, 011 layer 1
- pool_first  out  1  first of four pool reads: compare register loads
- pool_en  out  1  pool read active: compare register takes max

## Operation
- States: IDLE, CONV, CWR, POOL, PWR, DONE.
- IDLE: `ready`=1 sampled → CONV, pixel=0, k=0, `busy`=1 next cycle.
- CONV: one tap per cycle, k=0..8; `dr=k/3-1`, `dc=k%3-1`; neighbour (r+dr, c+dc) for pixel (r,c)=(pixel/64, pixel%64). Out of range → `pad`=1, `iaddr`=0; else `iaddr`=(r+dr)*64+(c+dc). `mac_en`=1 all taps, `mac_first`=1 at k=0. After k=8 → CWR.
- CWR: `cwr`=1, `csel`=001, `caddr_wr`=pixel. pixel<4095 → pixel+1, CONV; else → POOL, p=0, j=0.
- POOL: j=0..3 reads of L0 at base=(2·pr)·64+2·pc, order base, base+1, base+64, base+65; `crd`=1, `csel`=001, `pool_en`=1, `pool_first`=1 at j=0. After j=3 → PWR.
- PWR: `cwr`=1, `csel`=011, `caddr_wr`=p (p=pr·32+pc). p<1023 → p+1, POOL; else → DONE.
- DONE: `busy`=0, → IDLE. `ready` still high in IDLE starts a new run.
- `ready` is ignored outside IDLE.
- All counters wrap-free; terminal values are compared explicitly, never via overflow.

## Timing
- All outputs are registered; reset values: `busy`=0, `crd`=0, `cwr`=0, `csel`=000, `iaddr`=0, `caddr_rd`=0, `caddr_wr`=0, `kidx`=0, `pad`=0, `mac_en`=0, `mac_first`=0, `pool_en`=0, `pool_first`=0.
- Memory model: address driven after posedge; data returned on the following negedge; consumed at the next posedge. No wait states.
- Per-pixel convolution takes 10 cycles (9 taps + 1 write). Per-pool output takes 5 cycles. `busy` high for exactly 4096·10 + 1024·5 = 46080 cycles.
- First layer-0 write occurs 10 cycles after `busy` rises. The first pool read is the cycle after the write of L0 pixel 4095; no read-after-write hazard exists.
- Reset asserted mid-run: outputs return to reset values immediately (asynchronous) and the FSM returns to IDLE. No partial write completes after reset assertion.
- Outside their own states, `cwr`, `crd`, `mac_en`, and `pool_en` are 0, and `csel`=000.

## Structure
- `conv_pkg`: state enum, IMG_W/POOL_W/AW, CSEL_IDLE=3'b000, CSEL_L0=3'b001, CSEL_L1=3'b011, tap offset function k→(dr,dc).
- Sub-module `conv_tap_addr`: combinational (r,c,k) → {pad, iaddr}, exhaustively testable standalone.
- Top: FSM, pixel/k/p/j counters, output registers.

## Test plan
- Reset: hold `reset`=0 with `ready`=1 → every output at its reset value; release → `busy`=1 one cycle after the first `ready` sample.
- Pixel 0 taps → `pad`=1 for k=0,1,2,3,6; `iaddr`=0,1,64,65 for k=4,5,7,8; then `cwr`=1, `caddr_wr`=0, `csel`=001.
- Pixel 65 → `iaddr` sequence 0,1,2,64,65,66,128,129,130, no `pad`. Pixel 4095 → valid taps 4030,4031,4094,4095 at k=0,1,3,4; others `pad`.
- Pool output 33 → `crd` addresses 130,131,194,195 with `pool_first` on 130; then `cwr`, `caddr_wr`=33, `csel`=011.
- Full run → `busy` high for exactly 46080 cycles; write counts 4096 (`csel`=001) and 1024 (`csel`=011); no address is written twice.
- `reset`=0 at cycle 20000 → outputs reset in the same cycle; a restart from `ready` reproduces the full run bit-exactly.
